// File: rtl/doodle_pkg.sv
// Shared types and constants for the doodle game datapath: platform slot
// layout, doodle hitbox geometry and the landing scanner state encoding.
package doodle_pkg;

  // Platform field geometry
  localparam int N_PLATFORMS     = 90;
  localparam int IDX_W           = 7;   // wide enough to address every slot
  localparam int PLATFORM_WIDTH  = 57;
  localparam int PLATFORM_HEIGHT = 15;  // sprite height; the landing test only uses the top edge

  // Doodle hitbox and landing rules
  localparam int DOODLE_WIDTH  = 60;
  localparam int DOODLE_HEIGHT = 60;
  localparam int LAND_TOL      = 8;     // feet may sink this far below a platform top
  localparam int SCROLL_LINE   = 300;   // landing above this row scrolls the world

  // One platform slot: [0] = top Y, [1] = left X, both signed screen coordinates
  typedef logic signed [1:0][10:0] platform_t;

  // Doodle state frozen at the frame tick so the whole scan sees one position
  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic        falling;
  } doodle_snap_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } scan_state_t;

endpackage

// File: rtl/landing_cmp.sv
// Single-slot landing test: does the snapshotted doodle stand on this platform?
// Purely combinational; the scanner time-multiplexes one instance over all slots.
module landing_cmp
  import doodle_pkg::*;
(
  input  platform_t    platform_i,
  input  logic         active_i,
  input  doodle_snap_t snap_i,
  output logic         hit_o
);

  // All geometry is done in 13-bit signed so negative platform Y (above the
  // screen) compares correctly against the always-positive doodle coordinates.
  logic signed [12:0] py;
  logic signed [12:0] px;
  logic signed [12:0] py_tol;
  logic signed [12:0] px_right;
  logic signed [12:0] feet;
  logic signed [12:0] dx;
  logic signed [12:0] dx_right;

  // Evaluate the vertical window and the horizontal overlap for one slot
  // NOTE: every signal written in always_comb gets a value on every path, otherwise synthesis infers a latch.
  always_comb begin
    py       = {{2{platform_i[0][10]}}, platform_i[0]};
    px       = {{2{platform_i[1][10]}}, platform_i[1]};
    py_tol   = py + 13'(LAND_TOL);
    px_right = px + 13'(PLATFORM_WIDTH - 1);
    feet     = {3'b000, snap_i.y} + 13'(DOODLE_HEIGHT);
    dx       = {2'b00, snap_i.x};
    dx_right = dx + 13'(DOODLE_WIDTH - 1);

    hit_o = active_i
         && snap_i.falling
         && (feet >= py)
         && (feet <= py_tol)
         && (dx_right >= px)
         && (dx <= px_right);
  end

endmodule

// File: rtl/platform_landing_scanner.sv
// Per-frame landing scanner: on each frame tick walks all platform slots, one
// per clock, through a single shared comparator and reports the first (lowest
// index) platform the falling doodle has landed on, plus a world-scroll request.
module platform_landing_scanner
  import doodle_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   frame_tick,
  input  logic signed [N_PLATFORMS-1:0][1:0][10:0] platforms,
  input  logic [N_PLATFORMS-1:0]                 platform_activation,
  input  logic [10:0]                            doodle_x,
  input  logic [9:0]                             doodle_y,
  input  logic                                   doodle_falling,
  output logic                                   landed,
  output logic [IDX_W-1:0]                       landed_idx,
  output logic signed [10:0]                     landed_top_y,
  output logic                                   move_collision,
  output logic                                   busy
);

  scan_state_t        state_q;
  logic [IDX_W-1:0]   idx_q;
  doodle_snap_t       snap_q;
  logic               busy_q;
  logic               landed_q;
  logic [IDX_W-1:0]   landed_idx_q;
  logic signed [10:0] landed_top_y_q;
  logic               move_collision_q;

  // Slot under test this cycle; platform inputs are stable between ticks so
  // they are read live rather than copied.
  platform_t          cur_platform;
  logic               cur_active;
  logic signed [10:0] cur_py;
  logic               cur_hit;

  assign cur_platform = platforms[idx_q];
  assign cur_active   = platform_activation[idx_q];
  assign cur_py       = cur_platform[0];

  landing_cmp u_landing_cmp (
    .platform_i (cur_platform),
    .active_i   (cur_active),
    .snap_i     (snap_q),
    .hit_o      (cur_hit)
  );

  // Scan FSM with registered outputs: IDLE waits for a tick, SCAN walks the
  // slots until the first hit or the last slot, DONE presents the result.
  // NOTE: state registers use non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      idx_q            <= '0;
      snap_q           <= '0;
      busy_q           <= 1'b0;
      landed_q         <= 1'b0;
      landed_idx_q     <= '0;
      landed_top_y_q   <= '0;
      move_collision_q <= 1'b0;
    end else begin
      landed_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (frame_tick) begin
            snap_q  <= '{x: doodle_x, y: doodle_y, falling: doodle_falling};
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (cur_hit) begin
            landed_q         <= 1'b1;
            landed_idx_q     <= idx_q;
            landed_top_y_q   <= cur_py;
            move_collision_q <= (cur_py < 11'(SCROLL_LINE));
            state_q          <= ST_DONE;
          end else if (idx_q == IDX_W'(N_PLATFORMS - 1)) begin
            move_collision_q <= 1'b0;
            state_q          <= ST_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end

        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign landed         = landed_q;
  assign landed_idx     = landed_idx_q;
  assign landed_top_y   = landed_top_y_q;
  assign move_collision = move_collision_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_platform_landing_scanner.sv
// Directed-vector bench for platform_landing_scanner: timing of the landed
// pulse, lowest-index priority, landing window and horizontal edges, result
// hold across misses, ignored ticks while busy, and reset mid-scan.
module tb_platform_landing_scanner;

  logic                        clk;
  logic                        rst;
  logic                        frame_tick;
  logic signed [89:0][1:0][10:0] platforms;
  logic [89:0]                 platform_activation;
  logic [10:0]                 doodle_x;
  logic [9:0]                  doodle_y;
  logic                        doodle_falling;
  logic                        landed;
  logic [6:0]                  landed_idx;
  logic signed [10:0]          landed_top_y;
  logic                        move_collision;
  logic                        busy;

  int checks = 0;
  int errors = 0;

  platform_landing_scanner dut (
    .clk                 (clk),
    .rst                 (rst),
    .frame_tick          (frame_tick),
    .platforms           (platforms),
    .platform_activation (platform_activation),
    .doodle_x            (doodle_x),
    .doodle_y            (doodle_y),
    .doodle_falling      (doodle_falling),
    .landed              (landed),
    .landed_idx          (landed_idx),
    .landed_top_y        (landed_top_y),
    .move_collision      (move_collision),
    .busy                (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_slots();
    for (int i = 0; i < 90; i++) begin
      platforms[i][0] = 11'sd1000;
      platforms[i][1] = 11'sd0;
    end
    platform_activation = '0;
  endtask

  task automatic set_slot(input int i, input int py, input int px, input bit act);
    platforms[i][0]        = 11'(py);
    platforms[i][1]        = 11'(px);
    platform_activation[i] = act;
  endtask

  task automatic set_doodle(input int x, input int y, input bit falling);
    doodle_x       = 11'(x);
    doodle_y       = 10'(y);
    doodle_falling = falling;
  endtask

  // Tick is high during cycle T; returns #1 into cycle T+1.
  task automatic pulse_tick();
    @(posedge clk);
    #1 frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
  endtask

  // Follows a scan cycle by cycle (cycle n = T+n). Records the cycle of the
  // landed pulse and the first cycle busy is low. Optionally raises an extra
  // tick in cycle extra_at. Stops after budget cycles.
  task automatic watch(input int budget, input int extra_at,
                       output int land_cyc, output int idle_cyc,
                       output int l_idx, output int l_top, output int l_move);
    int cyc;
    cyc      = 1;
    land_cyc = -1;
    idle_cyc = -1;
    l_idx    = -1;
    l_top    = -1;
    l_move   = -1;
    while (cyc <= budget) begin
      if (landed === 1'b1 && land_cyc < 0) begin
        land_cyc = cyc;
        l_idx    = int'(landed_idx);
        l_top    = int'(landed_top_y);
        l_move   = int'(move_collision);
      end
      if (busy !== 1'b1) begin
        idle_cyc = cyc;
        break;
      end
      if (cyc == extra_at) frame_tick = 1'b1;
      @(posedge clk);
      #1 frame_tick = 1'b0;
      cyc++;
    end
  endtask

  // One full scan. exp_slot < 0 means no landing is expected; the held
  // output values are checked once the scanner is idle again.
  task automatic scan_and_check(input string tag, input int exp_slot,
                                input int exp_idx, input int exp_top,
                                input int exp_move);
    int land_cyc, idle_cyc, l_idx, l_top, l_move;
    pulse_tick();
    watch(120, -1, land_cyc, idle_cyc, l_idx, l_top, l_move);
    if (exp_slot >= 0) begin
      check({tag, ".land_cycle"}, land_cyc, exp_slot + 2);
      check({tag, ".idle_cycle"}, idle_cyc, exp_slot + 3);
      check({tag, ".pulse_idx"},  l_idx,    exp_slot);
    end else begin
      check({tag, ".land_cycle"}, land_cyc, -1);
      check({tag, ".idle_cycle"}, idle_cyc, 92);
    end
    check({tag, ".landed_idx"},     int'(landed_idx),     exp_idx);
    check({tag, ".landed_top_y"},   int'(landed_top_y),   exp_top);
    check({tag, ".move_collision"}, int'(move_collision), exp_move);
  endtask

  initial begin
    int land_cyc, idle_cyc, l_idx, l_top, l_move;
    int pulses;

    rst        = 1'b1;
    frame_tick = 1'b0;
    clear_slots();
    set_doodle(0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy",           int'(busy),           0);
    check("reset.landed",         int'(landed),         0);
    check("reset.landed_idx",     int'(landed_idx),     0);
    check("reset.landed_top_y",   int'(landed_top_y),   0);
    check("reset.move_collision", int'(move_collision), 0);
    rst = 1'b0;

    // Plain landing below the scroll line: feet 400 on top 400.
    set_slot(5, 400, 342, 1'b1);
    set_doodle(350, 340, 1'b1);
    scan_and_check("t1", 5, 5, 400, 0);

    // Landing above the scroll line requests a scroll; level holds.
    set_slot(5, 200, 342, 1'b1);
    set_doodle(350, 145, 1'b1);
    scan_and_check("t2", 5, 5, 200, 1);
    repeat (5) @(posedge clk);
    #1 check("t2.move_hold", int'(move_collision), 1);

    // Rising doodle never lands; previous hit values are kept.
    set_doodle(350, 145, 1'b0);
    scan_and_check("t4_not_falling", -1, 5, 200, 0);

    // Two candidates: the lower index wins.
    clear_slots();
    set_slot(3, 400, 342, 1'b1);
    set_slot(40, 400, 342, 1'b1);
    set_doodle(350, 340, 1'b1);
    scan_and_check("t3", 3, 3, 400, 0);

    // Feet 409 is one past the tolerance; feet 408 is the last hit.
    set_doodle(350, 349, 1'b1);
    scan_and_check("t4_tol_miss", -1, 3, 400, 0);
    set_doodle(350, 348, 1'b1);
    scan_and_check("t4_tol_edge", 3, 3, 400, 0);

    // Geometry matches but nothing is active.
    platform_activation = '0;
    set_doodle(350, 340, 1'b1);
    scan_and_check("t4_inactive", -1, 3, 400, 0);

    // Horizontal edges around px=342 (platform spans 342..398).
    clear_slots();
    set_slot(5, 400, 342, 1'b1);
    set_doodle(283, 340, 1'b1);
    scan_and_check("t5_x283", 5, 5, 400, 0);
    clear_slots();
    set_slot(4, 400, 342, 1'b1);
    set_doodle(282, 340, 1'b1);
    scan_and_check("t5_x282", -1, 5, 400, 0);
    set_doodle(398, 340, 1'b1);
    scan_and_check("t5_x398", 4, 4, 400, 0);
    set_doodle(399, 340, 1'b1);
    scan_and_check("t5_x399", -1, 4, 400, 0);

    // Platform above the screen top never catches the feet.
    clear_slots();
    set_slot(7, -5, 342, 1'b1);
    set_doodle(350, 0, 1'b1);
    scan_and_check("neg_py", -1, 4, 400, 0);

    // A tick in the middle of a scan is dropped, not queued.
    clear_slots();
    set_slot(80, 200, 342, 1'b1);
    set_doodle(350, 145, 1'b1);
    pulse_tick();
    watch(120, 10, land_cyc, idle_cyc, l_idx, l_top, l_move);
    check("t6_ignore.land_cycle", land_cyc, 82);
    check("t6_ignore.idle_cycle", idle_cyc, 83);
    check("t6_ignore.pulse_idx",  l_idx,    80);
    check("t6_ignore.pulse_move", l_move,   1);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 if (busy !== 1'b0) pulses++;
    end
    check("t6_ignore.no_requeue", pulses, 0);

    // Reset in cycle T+20 aborts the scan with no landed pulse.
    pulse_tick();
    watch(19, 10, land_cyc, idle_cyc, l_idx, l_top, l_move);
    check("t6_rst.still_busy", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("t6_rst.busy",           int'(busy),           0);
    check("t6_rst.landed",         int'(landed),         0);
    check("t6_rst.move_collision", int'(move_collision), 0);
    check("t6_rst.landed_idx",     int'(landed_idx),     0);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1 if (landed !== 1'b0 || busy !== 1'b0) pulses++;
    end
    check("t6_rst.quiet_after", pulses, 0);

    // Next tick restarts from slot 0 with full timing.
    scan_and_check("t6_restart", 80, 80, 200, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
